armleocpu_csr_sequencer: RTL and testbench

Sequences CSR-class instructions (CSRRW/RS/RC and their immediate forms) from the execute stage onto the single-command CSR file port. Each instruction becomes an ordered READ then WRITE on that port, with the write value computed in between. Read-only and write-only shortcuts from the RISC-V rules are applied. Illegal and privilege faults reported by the CSR file are returned to the pipeline as a one-cycle response.

---
 rtl/armleocpu_csr_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_armleocpu_csr_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_csr_sequencer.sv
// armleocpu_csr_sequencer
// Runs one CSR-class instruction from execute on the single-command CSR file
// port: an optional READ, then an optional WRITE, then a one-cycle response.
// The write value is RW: operand, RS: old | operand, RC: old & ~operand.

package armleocpu_csr_sequencer_pkg;
    localparam int ARMLEOCPU_CSR_CMD_WIDTH = 2;
    localparam logic [ARMLEOCPU_CSR_CMD_WIDTH-1:0] ARMLEOCPU_CSR_CMD_NONE  = 2'd0;
    localparam logic [ARMLEOCPU_CSR_CMD_WIDTH-1:0] ARMLEOCPU_CSR_CMD_READ  = 2'd1;
    localparam logic [ARMLEOCPU_CSR_CMD_WIDTH-1:0] ARMLEOCPU_CSR_CMD_WRITE = 2'd2;
endpackage

module armleocpu_csr_sequencer
    import armleocpu_csr_sequencer_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               kill,

    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [2:0]                         req_funct3,
    input  logic [11:0]                        req_address,
    input  logic [31:0]                        req_rs1_value,
    input  logic [4:0]                         req_rs1_index,
    input  logic [4:0]                         req_rd_index,

    output logic                               resp_valid,
    output logic                               resp_illegal,
    output logic                               resp_rd_write,
    output logic [4:0]                         resp_rd_index,
    output logic [31:0]                        resp_rd_data,

    output logic [ARMLEOCPU_CSR_CMD_WIDTH-1:0] csr_cmd,
    output logic [11:0]                        csr_address,
    output logic [31:0]                        csr_writedata,
    input  logic [31:0]                        csr_readdata,
    input  logic                               csr_invalid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    // Sequencer state and fields latched at acceptance
    state_t      state_q;
    logic [1:0]  op_q;
    logic [11:0] address_q;
    logic [4:0]  rd_index_q;
    logic [31:0] operand_q;
    logic [31:0] old_q;
    logic        illegal_q;
    logic        need_read_q;
    logic        need_write_q;

    // Decode of the incoming request, used only on the accepting edge
    logic        accept_d;
    logic [31:0] operand_d;
    logic        funct3_illegal_d;
    logic        need_read_d;
    logic        need_write_d;

    // Value presented on the CSR port during WRITE
    logic [31:0] write_value_d;

    // Decode the request: immediate forms take zimm from the rs1 index field
    always_comb begin
        accept_d         = (state_q == ST_IDLE) && req_valid && !kill;
        operand_d        = req_funct3[2] ? {27'b0, req_rs1_index} : req_rs1_value;
        funct3_illegal_d = (req_funct3[1:0] == 2'b00);
        // CSRRW with rd=x0 must not read (no read side effects)
        need_read_d      = !((req_funct3[1:0] == OP_RW) && (req_rd_index == 5'd0));
        // CSRRS/CSRRC with rs1/zimm of zero must not write
        need_write_d     = (req_funct3[1:0] == OP_RW) || (req_rs1_index != 5'd0);
    end

    // Combine the captured old value with the operand according to the opcode
    always_comb begin
        write_value_d = operand_q;
        case (op_q)
            OP_RS:   write_value_d = old_q | operand_q;
            OP_RC:   write_value_d = old_q & ~operand_q;
            default: write_value_d = operand_q;
        endcase
    end

    // Sequencer FSM: latch on accept, READ then WRITE, then one response cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= 2'b00;
            address_q    <= 12'h000;
            rd_index_q   <= 5'd0;
            operand_q    <= 32'h0;
            old_q        <= 32'h0;
            illegal_q    <= 1'b0;
            need_read_q  <= 1'b0;
            need_write_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        op_q         <= req_funct3[1:0];
                        address_q    <= req_address;
                        rd_index_q   <= req_rd_index;
                        operand_q    <= operand_d;
                        need_read_q  <= need_read_d;
                        need_write_q <= need_write_d;
                        illegal_q    <= funct3_illegal_d;
                        if (funct3_illegal_d)
                            state_q <= ST_RESP;
                        else if (need_read_d)
                            state_q <= ST_READ;
                        else
                            state_q <= ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (kill) begin
                        state_q <= ST_IDLE;
                    end else begin
                        old_q <= csr_readdata;
                        if (csr_invalid) begin
                            illegal_q <= 1'b1;
                            state_q   <= ST_RESP;
                        end else if (need_write_q) begin
                            state_q <= ST_WRITE;
                        end else begin
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_WRITE: begin
                    if (kill) begin
                        state_q <= ST_IDLE;
                    end else begin
                        if (csr_invalid)
                            illegal_q <= 1'b1;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Drive the CSR port and the response from the current state; kill gates
    // the command and the response pulse in the same cycle
    always_comb begin
        req_ready     = 1'b0;
        csr_cmd       = ARMLEOCPU_CSR_CMD_NONE;
        csr_address   = 12'h000;
        csr_writedata = 32'h0;
        resp_valid    = 1'b0;
        resp_illegal  = 1'b0;
        resp_rd_write = 1'b0;
        resp_rd_index = 5'd0;
        resp_rd_data  = 32'h0;
        case (state_q)
            ST_IDLE: begin
                req_ready = !kill;
            end
            ST_READ: begin
                csr_address = address_q;
                if (!kill)
                    csr_cmd = ARMLEOCPU_CSR_CMD_READ;
            end
            ST_WRITE: begin
                csr_address   = address_q;
                csr_writedata = write_value_d;
                if (!kill)
                    csr_cmd = ARMLEOCPU_CSR_CMD_WRITE;
            end
            ST_RESP: begin
                resp_valid    = !kill;
                resp_illegal  = illegal_q;
                resp_rd_write = !illegal_q && need_read_q && (rd_index_q != 5'd0);
                resp_rd_index = rd_index_q;
                resp_rd_data  = old_q;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_armleocpu_csr_sequencer.sv
// Bench for armleocpu_csr_sequencer: a small CSR file (mscratch at 0x340,
// a read-only register at 0xFC0, everything else unimplemented) sits on the
// CSR port; a transaction-level model predicts every cycle's outputs.
module tb_armleocpu_csr_sequencer;
    import armleocpu_csr_sequencer_pkg::*;

    localparam logic [31:0] RO_VALUE = 32'hABCD_0001;
    localparam int PH_READ  = 1;
    localparam int PH_WRITE = 2;
    localparam int PH_RESP  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        kill = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = 3'd0;
    logic [11:0] req_address = 12'h0;
    logic [31:0] req_rs1_value = 32'h0;
    logic [4:0]  req_rs1_index = 5'd0;
    logic [4:0]  req_rd_index = 5'd0;
    logic        resp_valid;
    logic        resp_illegal;
    logic        resp_rd_write;
    logic [4:0]  resp_rd_index;
    logic [31:0] resp_rd_data;
    logic [ARMLEOCPU_CSR_CMD_WIDTH-1:0] csr_cmd;
    logic [11:0] csr_address;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata;
    logic        csr_invalid;

    armleocpu_csr_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .kill          (kill),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_funct3    (req_funct3),
        .req_address   (req_address),
        .req_rs1_value (req_rs1_value),
        .req_rs1_index (req_rs1_index),
        .req_rd_index  (req_rd_index),
        .resp_valid    (resp_valid),
        .resp_illegal  (resp_illegal),
        .resp_rd_write (resp_rd_write),
        .resp_rd_index (resp_rd_index),
        .resp_rd_data  (resp_rd_data),
        .csr_cmd       (csr_cmd),
        .csr_address   (csr_address),
        .csr_writedata (csr_writedata),
        .csr_readdata  (csr_readdata),
        .csr_invalid   (csr_invalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- CSR file environment ----------------
    logic [31:0] env_mscratch = 32'h0;
    int          env_writes = 0;

    always_comb begin
        csr_readdata = 32'h0;
        csr_invalid  = 1'b0;
        if (csr_cmd != ARMLEOCPU_CSR_CMD_NONE) begin
            if (csr_address == 12'h340) begin
                csr_readdata = env_mscratch;
            end else if (csr_address == 12'hFC0) begin
                csr_readdata = RO_VALUE;
                csr_invalid  = (csr_cmd == ARMLEOCPU_CSR_CMD_WRITE);
            end else begin
                csr_invalid = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (csr_cmd == ARMLEOCPU_CSR_CMD_WRITE && !csr_invalid && csr_address == 12'h340) begin
            env_mscratch <= csr_writedata;
            env_writes   <= env_writes + 1;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    endtask

    bit          check_en = 1'b0;
    logic        exp_ready;
    logic [1:0]  exp_cmd;
    logic [11:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_rv;
    logic        exp_ill;
    logic        exp_rdw;
    logic [4:0]  exp_rdi;
    logic [31:0] exp_rdd;

    int          seen_cyc = -1;
    logic        seen_ill = 1'b0;
    logic        seen_rdw = 1'b0;
    logic [31:0] seen_rdd = 32'h0;
    int          resp_count = 0;

    // Per-cycle compare of every output against the model's expectation
    always @(negedge clk) begin
        if (check_en) begin
            chk("req_ready",     32'(req_ready),     32'(exp_ready));
            chk("csr_cmd",       32'(csr_cmd),       32'(exp_cmd));
            chk("csr_address",   32'(csr_address),   32'(exp_addr));
            chk("csr_writedata", csr_writedata,      exp_wdata);
            chk("resp_valid",    32'(resp_valid),    32'(exp_rv));
            chk("resp_illegal",  32'(resp_illegal),  32'(exp_ill));
            chk("resp_rd_write", 32'(resp_rd_write), 32'(exp_rdw));
            chk("resp_rd_index", 32'(resp_rd_index), 32'(exp_rdi));
            chk("resp_rd_data",  resp_rd_data,       exp_rdd);
        end
        if (resp_valid) begin
            seen_cyc = cyc;
            seen_ill = resp_illegal;
            seen_rdw = resp_rd_write;
            seen_rdd = resp_rd_data;
            resp_count++;
        end
    end

    // ---------------- model ----------------
    logic [31:0] model_mscratch = 32'h0;
    logic [31:0] model_old = 32'h0;
    int          accept_cyc = 0;

    function automatic bit model_impl(input logic [11:0] a);
        return (a == 12'h340) || (a == 12'hFC0);
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        if (a == 12'h340) return model_mscratch;
        if (a == 12'hFC0) return RO_VALUE;
        return 32'h0;
    endfunction

    task automatic set_exp_idle(input logic ready);
        exp_ready = ready;
        exp_cmd   = ARMLEOCPU_CSR_CMD_NONE;
        exp_addr  = 12'h0;
        exp_wdata = 32'h0;
        exp_rv    = 1'b0;
        exp_ill   = 1'b0;
        exp_rdw   = 1'b0;
        exp_rdi   = 5'd0;
        exp_rdd   = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction; kill_at / rst_at select a phase index (0 = first cycle
    // after acceptance) to disturb, -1 for none.
    task automatic do_instr(input logic [2:0] f3, input logic [11:0] a,
                            input logic [31:0] v, input logic [4:0] idx,
                            input logic [4:0] rd, input int kill_at, input int rst_at);
        logic [1:0]  op;
        logic [31:0] opnd;
        logic [31:0] wd;
        bit          nr, nw, ill, done;
        int          ph[$];

        op   = f3[1:0];
        opnd = f3[2] ? {27'b0, idx} : v;
        nr   = !(op == 2'b01 && rd == 5'd0);
        nw   = (op == 2'b01) || (idx != 5'd0);
        ill  = (op == 2'b00);

        if (ill) begin
            ph.push_back(PH_RESP);
        end else begin
            if (nr) ph.push_back(PH_READ);
            if (nw && (!nr || model_impl(a))) ph.push_back(PH_WRITE);
            ph.push_back(PH_RESP);
        end

        seen_cyc      = -1;
        req_valid     = 1'b1;
        req_funct3    = f3;
        req_address   = a;
        req_rs1_value = v;
        req_rs1_index = idx;
        req_rd_index  = rd;
        accept_cyc    = cyc;
        set_exp_idle(1'b1);
        step();
        // Scramble the request bus so only latched fields can be used
        req_valid     = 1'b0;
        req_funct3    = ~f3;
        req_address   = ~a;
        req_rs1_value = ~v;
        req_rs1_index = ~idx;
        req_rd_index  = ~rd;

        done = 1'b0;
        for (int i = 0; i < ph.size() && !done; i++) begin
            bit k;
            bit r;
            k = (i == kill_at);
            r = (i == rst_at);
            kill  = k;
            rst_n = !r;
            set_exp_idle(1'b0);
            wd = 32'h0;
            if (ph[i] == PH_READ) begin
                exp_cmd  = k ? ARMLEOCPU_CSR_CMD_NONE : ARMLEOCPU_CSR_CMD_READ;
                exp_addr = a;
            end else if (ph[i] == PH_WRITE) begin
                case (op)
                    2'b10:   wd = model_old | opnd;
                    2'b11:   wd = model_old & ~opnd;
                    default: wd = opnd;
                endcase
                exp_cmd   = k ? ARMLEOCPU_CSR_CMD_NONE : ARMLEOCPU_CSR_CMD_WRITE;
                exp_addr  = a;
                exp_wdata = wd;
            end else begin
                exp_rv  = !k;
                exp_ill = ill;
                exp_rdw = !ill && nr && (rd != 5'd0);
                exp_rdi = rd;
                exp_rdd = model_old;
            end
            step();
            if (k) begin
                kill = 1'b0;
                done = 1'b1;
            end else begin
                if (ph[i] == PH_WRITE) begin
                    if (a == 12'h340) model_mscratch = wd;
                    else ill = 1'b1;
                end
                if (ph[i] == PH_READ) begin
                    model_old = model_read(a);
                    if (!model_impl(a)) ill = 1'b1;
                end
            end
            if (r) begin
                model_old = 32'h0;
                rst_n = 1'b1;
                done = 1'b1;
            end
        end

        set_exp_idle(1'b1);
        step();
        $display("instr f3=%0d addr=0x%03h rd=x%0d kill_at=%0d rst_at=%0d resp_latency=%0d",
                 f3, a, rd, kill_at, rst_at, (seen_cyc < 0) ? -1 : seen_cyc - accept_cyc);
    endtask

    // ---------------- stimulus ----------------
    int w0;
    int r0;

    initial begin
        set_exp_idle(1'b1);
        step();
        check_en = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        step();

        // Write-only CSRRW x0: mscratch = 0x11, response at c2
        do_instr(3'b001, 12'h340, 32'h0000_0011, 5'd7, 5'd0, -1, -1);
        chk("wo_latency", 32'(seen_cyc - accept_cyc), 32'd2);
        chk("wo_mscratch", env_mscratch, 32'h0000_0011);

        // CSRRW x5, 0x340, 0xDEADBEEF
        do_instr(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd6, 5'd5, -1, -1);
        chk("rw_latency", 32'(seen_cyc - accept_cyc), 32'd3);
        chk("rw_rd_data", seen_rdd, 32'h0000_0011);
        chk("rw_rd_write", 32'(seen_rdw), 32'd1);
        chk("rw_mscratch", env_mscratch, 32'hDEAD_BEEF);

        // CSRRS x0, rs1 idx 0: read only, no write
        w0 = env_writes;
        do_instr(3'b010, 12'h340, 32'hFFFF_FFFF, 5'd0, 5'd0, -1, -1);
        chk("ro_latency", 32'(seen_cyc - accept_cyc), 32'd2);
        chk("ro_no_write", 32'(env_writes), 32'(w0));
        chk("ro_rd_write", 32'(seen_rdw), 32'd0);

        // mscratch = 0xFF, then CSRRCI x3, zimm 0x0F
        do_instr(3'b001, 12'h340, 32'h0000_00FF, 5'd1, 5'd0, -1, -1);
        do_instr(3'b111, 12'h340, 32'h1234_5678, 5'h0F, 5'd3, -1, -1);
        chk("rci_rd_data", seen_rdd, 32'h0000_00FF);
        chk("rci_mscratch", env_mscratch, 32'h0000_00F0);

        // CSRRSI x4, zimm 3
        do_instr(3'b110, 12'h340, 32'h0, 5'd3, 5'd4, -1, -1);
        chk("rsi_rd_data", seen_rdd, 32'h0000_00F0);
        chk("rsi_mscratch", env_mscratch, 32'h0000_00F3);

        // CSRRW x1 to read-only 0xFC0: write faults
        do_instr(3'b001, 12'hFC0, 32'h0000_0005, 5'd2, 5'd1, -1, -1);
        chk("ro_csr_illegal", 32'(seen_ill), 32'd1);
        chk("ro_csr_rd_write", 32'(seen_rdw), 32'd0);
        chk("ro_csr_mscratch", env_mscratch, 32'h0000_00F3);

        // Illegal funct3 100 and 000: response at c1
        do_instr(3'b100, 12'h340, 32'h1, 5'd1, 5'd9, -1, -1);
        chk("f3_100_latency", 32'(seen_cyc - accept_cyc), 32'd1);
        chk("f3_100_illegal", 32'(seen_ill), 32'd1);
        do_instr(3'b000, 12'h340, 32'h1, 5'd1, 5'd9, -1, -1);
        chk("f3_000_illegal", 32'(seen_ill), 32'd1);

        // CSRRS x2 to unimplemented CSR: READ faults
        do_instr(3'b010, 12'h7AB, 32'h1, 5'd1, 5'd2, -1, -1);
        chk("unimpl_latency", 32'(seen_cyc - accept_cyc), 32'd2);
        chk("unimpl_illegal", 32'(seen_ill), 32'd1);

        // kill in WRITE: no commit, no response
        r0 = resp_count;
        do_instr(3'b001, 12'h340, 32'h1234_5678, 5'd6, 5'd5, 1, -1);
        chk("kill_mscratch", env_mscratch, 32'h0000_00F3);
        chk("kill_no_resp", 32'(resp_count), 32'(r0));

        // reset during READ: abandoned, nothing written
        w0 = env_writes;
        r0 = resp_count;
        do_instr(3'b001, 12'h340, 32'h0000_CAFE, 5'd6, 5'd5, -1, 0);
        chk("rst_no_write", 32'(env_writes), 32'(w0));
        chk("rst_no_resp", 32'(resp_count), 32'(r0));

        // kill in IDLE blocks acceptance
        req_valid     = 1'b1;
        req_funct3    = 3'b001;
        req_address   = 12'h340;
        req_rs1_value = 32'h5555_5555;
        req_rs1_index = 5'd1;
        req_rd_index  = 5'd1;
        kill          = 1'b1;
        set_exp_idle(1'b0);
        step();
        req_valid = 1'b0;
        kill      = 1'b0;
        set_exp_idle(1'b1);
        step();
        step();
        $display("instr kill-in-idle request offered and dropped");

        // Back-to-back sanity after the disturbances
        do_instr(3'b010, 12'h340, 32'h0000_0100, 5'd8, 5'd10, -1, -1);
        chk("final_rd_data", seen_rdd, 32'h0000_00F3);
        chk("final_mscratch", env_mscratch, 32'h0000_01F3);
        chk("model_vs_env", env_mscratch, model_mscratch);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
